apb_master_bridge: RTL and testbench

- Upstream neighbour of the APB memory slave.
- Converts a valid/ready request stream from the test/system side into single APB transfers, using the SETUP then ACCESS phases.
- Waits on PREADY and returns read data and an error flag on a valid/ready response channel.
- Bounds slave wait states with a programmable timeout counter.

---
 rtl/apb_master_bridge_pkg.sv | 44 ++++
 rtl/apb_master_bridge_if.sv | 60 ++++++
 rtl/apb_master_bridge_wait_timer.sv | 47 ++++
 rtl/apb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared APB types for the master bridge and its neighbours.
//   ADDR_WIDTH / DATA_WIDTH : APB bus widths
//   addr_t / data_t         : bus word types
//   apb_mst_state_e         : bridge FSM states
//   apb_req_t / apb_rsp_t   : request and response payloads
//   cnt_width()             : width of a counter that must hold 0..limit
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
    } apb_req_t;

    typedef struct packed {
        data_t rdata;
        logic  slverr;
        logic  timeout;
    } apb_rsp_t;

    // $clog2(limit+1) is 0 for limit==0, and a zero-width vector is illegal.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// ----------------------------------------------------------------------------
// apb_if
// APB bus bundle between one master and one slave.
//   master_mp : PSEL, PENABLE, PWRITE, PADDR, PWDATA out; PREADY, PSLVERR,
//               PRDATA in. Reset is distributed separately, not via the bus.
//   slave_mp  : the mirror image.
//
// apb_mst_req_if
// Request/response stream into the APB master bridge.
//   bridge_mp : req_valid/req_write/req_addr/req_wdata/rsp_ready in;
//               req_ready/rsp_valid/rsp_rdata/rsp_slverr/rsp_timeout out.
//   client_mp : the mirror image.
// ----------------------------------------------------------------------------
interface apb_if;
    import apb_pkg::*;

    logic  PSEL;
    logic  PENABLE;
    logic  PWRITE;
    addr_t PADDR;
    data_t PWDATA;
    logic  PREADY;
    logic  PSLVERR;
    data_t PRDATA;

    modport master_mp (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave_mp (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR, PRDATA
    );
endinterface

interface apb_mst_req_if;
    import apb_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_write;
    addr_t req_addr;
    data_t req_wdata;
    logic  rsp_valid;
    logic  rsp_ready;
    data_t rsp_rdata;
    logic  rsp_slverr;
    logic  rsp_timeout;

    modport bridge_mp (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
    );

    modport client_mp (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
    );
endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles spent waiting for PREADY and flags the last allowed one.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset, clears the counter
//   i_clear   : synchronous clear (held while not in ACCESS)
//   i_enable  : count one wait cycle
//   o_expired : counter has reached TIMEOUT-1; never set when TIMEOUT==0
// ----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            // Saturating: a long wait must never wrap back to a small count.
            r_count <= r_count + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
            // Counter holds the number of waits already spent, so the
            // TIMEOUT-th ACCESS cycle is the one where count == TIMEOUT-1.
            assign o_expired = (r_count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
// Turns one valid/ready request into a single APB transfer (SETUP, ACCESS),
// waits on PREADY with a bounded wait-state budget, and returns the result on
// a valid/ready response channel.
//   PCLK    : clock
//   PRESET  : synchronous active-high reset; aborts any transfer silently
//   req_bus : request/response stream (bridge_mp)
//   apb     : APB master side (master_mp)
//   TIMEOUT : max ACCESS cycles waited for PREADY, 0 = wait forever
// ----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_mst_req_if.bridge_mp req_bus,
    apb_if.master_mp         apb
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    apb_mst_state_e r_state;
    apb_mst_state_e w_next_state;

    apb_req_t r_req;
    apb_rsp_t r_rsp;
    logic     r_psel;
    logic     r_penable;
    logic     r_rsp_valid;

    logic w_req_ready;
    logic w_accept;
    logic w_access_done;
    logic w_access_abort;
    logic w_tmr_clear;
    logic w_tmr_enable;
    logic w_expired;

    // Ready is gated by PRESET so nothing is handshaken during a reset cycle.
    assign w_req_ready    = (r_state == IDLE) && !PRESET;
    assign w_accept       = w_req_ready && req_bus.req_valid;
    assign w_access_done  = (r_state == ACCESS) && apb.PREADY;
    // PREADY wins over timeout: a slave answering on the last cycle completes.
    assign w_access_abort = (r_state == ACCESS) && !apb.PREADY && w_expired;

    assign w_tmr_clear  = (r_state != ACCESS);
    assign w_tmr_enable = (r_state == ACCESS) && !apb.PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_expired)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM next-state logic ----------------
    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch can be inferred from an incomplete case.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)                         w_next_state = SETUP;
            SETUP:                                         w_next_state = ACCESS;
            ACCESS:  if (w_access_done || w_access_abort)  w_next_state = RESP;
            RESP:    if (req_bus.rsp_ready)                w_next_state = IDLE;
            default:                                       w_next_state = IDLE;
        endcase
    end

    // ---------------- Bus and response registers ----------------
    // NOTE: the datapath registers are reset too, not just the FSM, because
    // they drive PADDR/PWDATA and rsp_rdata directly and must read 0 after reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_req       <= '0;
            r_rsp       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req.write <= req_bus.req_write;
                r_req.addr  <= req_bus.req_addr;
                // Reads drive PWDATA low so stale write data never leaks out.
                r_req.wdata <= req_bus.req_write ? req_bus.req_wdata : '0;
                r_psel      <= 1'b1;
                r_penable   <= 1'b0;
            end

            if (r_state == SETUP) begin
                r_penable <= 1'b1;
            end

            if (w_access_done) begin
                r_psel        <= 1'b0;
                r_penable     <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp.rdata   <= r_req.write ? '0 : apb.PRDATA;
                r_rsp.slverr  <= apb.PSLVERR;
                r_rsp.timeout <= 1'b0;
            end

            if (w_access_abort) begin
                r_psel        <= 1'b0;
                r_penable     <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp.rdata   <= '0;
                r_rsp.slverr  <= 1'b1;
                r_rsp.timeout <= 1'b1;
            end

            if ((r_state == RESP) && req_bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // ---------------- Output mapping ----------------
    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_req.write;
    assign apb.PADDR   = r_req.addr;
    assign apb.PWDATA  = r_req.wdata;

    assign req_bus.req_ready   = w_req_ready;
    assign req_bus.rsp_valid   = r_rsp_valid;
    assign req_bus.rsp_rdata   = r_rsp.rdata;
    assign req_bus.rsp_slverr  = r_rsp.slverr;
    assign req_bus.rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed bench for apb_master_bridge with TIMEOUT=4 and a small APB slave
// model (16-word memory, programmable wait states, error and hang controls).
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic pclk;
    logic preset;

    apb_if         apb ();
    apb_mst_req_if rq  ();

    apb_master_bridge #(
        .TIMEOUT (4)
    ) dut (
        .PCLK    (pclk),
        .PRESET  (preset),
        .req_bus (rq),
        .apb     (apb)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- APB slave model ----------------
    int    slv_waits = 0;
    logic  slv_err   = 1'b0;
    logic  slv_hang  = 1'b0;
    int    acc_cnt   = 0;
    data_t mem [16]  = '{4: 32'h5555_AAAA, 8: 32'h1234_5678, default: 32'h0};

    assign apb.PREADY  = apb.PSEL && apb.PENABLE && !slv_hang && (acc_cnt == slv_waits);
    // Garbage on PSLVERR/PRDATA while not ready: the bridge must ignore it.
    assign apb.PSLVERR = apb.PREADY ? slv_err : 1'b1;
    assign apb.PRDATA  = apb.PREADY ? mem[apb.PADDR[5:2]] : 32'hBAD0_BAD0;

    always @(posedge pclk) begin
        if (apb.PSEL && apb.PENABLE) acc_cnt <= acc_cnt + 1;
        else                         acc_cnt <= 0;
        if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE)
            mem[apb.PADDR[5:2]] <= apb.PWDATA;
    end

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transfer: accept, SETUP, ACCESS, response held `hold` cycles.
    task automatic run_xfer(input string tag, input logic wr, input addr_t a,
                            input data_t d, input int waits, input logic err,
                            input logic hang, input int hold,
                            output int en_cycles, output apb_rsp_t rsp);
        logic  stable;
        data_t exp_wd;
        exp_wd    = wr ? d : '0;
        slv_waits = waits;
        slv_err   = err;
        slv_hang  = hang;

        rq.req_valid = 1'b1;
        rq.req_write = wr;
        rq.req_addr  = a;
        rq.req_wdata = d;
        check({tag, "_req_ready"}, rq.req_ready, 1);

        @(posedge pclk); #1;
        // Scramble request inputs: they must be ignored after the accept edge.
        rq.req_valid = 1'b0;
        rq.req_write = !wr;
        rq.req_addr  = a ^ 32'hFFFF_0000;
        rq.req_wdata = ~d;
        check({tag, "_setup_psel"},    apb.PSEL, 1);
        check({tag, "_setup_penable"}, apb.PENABLE, 0);
        check({tag, "_paddr"},         apb.PADDR, a);
        check({tag, "_pwrite"},        apb.PWRITE, wr);
        check({tag, "_pwdata"},        apb.PWDATA, exp_wd);
        check({tag, "_busy_ready"},    rq.req_ready, 0);

        en_cycles = 0;
        stable    = 1'b1;
        for (int i = 0; i < 40 && !rq.rsp_valid; i++) begin
            @(posedge pclk); #1;
            if (apb.PSEL && apb.PENABLE) begin
                en_cycles++;
                stable &= (apb.PADDR == a) && (apb.PWDATA == exp_wd) && (apb.PWRITE == wr);
            end
        end
        check({tag, "_rsp_valid"},   rq.rsp_valid, 1);
        check({tag, "_bus_stable"},  stable, 1);
        check({tag, "_end_psel"},    apb.PSEL, 0);
        check({tag, "_end_penable"}, apb.PENABLE, 0);

        rsp = '{rdata: rq.rsp_rdata, slverr: rq.rsp_slverr, timeout: rq.rsp_timeout};
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge pclk); #1;
            stable &= rq.rsp_valid && (rq.rsp_rdata == rsp.rdata) &&
                      (rq.rsp_slverr == rsp.slverr) && (rq.rsp_timeout == rsp.timeout) &&
                      !rq.req_ready && !apb.PSEL;
        end
        check({tag, "_rsp_hold"}, stable, 1);

        rq.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rq.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, rq.rsp_valid, 0);
        check({tag, "_idle_ready"}, rq.req_ready, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int       en;
        apb_rsp_t rsp;

        preset       = 1'b1;
        rq.req_valid = 1'b0;
        rq.req_write = 1'b0;
        rq.req_addr  = '0;
        rq.req_wdata = '0;
        rq.rsp_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge pclk);
        #1;
        check("rst_psel",        apb.PSEL, 0);
        check("rst_penable",     apb.PENABLE, 0);
        check("rst_pwrite",      apb.PWRITE, 0);
        check("rst_paddr",       apb.PADDR, 0);
        check("rst_pwdata",      apb.PWDATA, 0);
        check("rst_rsp_valid",   rq.rsp_valid, 0);
        check("rst_rsp_rdata",   rq.rsp_rdata, 0);
        check("rst_rsp_slverr",  rq.rsp_slverr, 0);
        check("rst_rsp_timeout", rq.rsp_timeout, 0);
        check("rst_req_ready",   rq.req_ready, 0);
        preset = 1'b0;
        #1;
        check("rst_release_ready", rq.req_ready, 1);

        // ---- zero-wait write ----
        run_xfer("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 0, en, rsp);
        check("wr10_en_cycles", en, 1);
        check("wr10_rdata",     rsp.rdata, 0);
        check("wr10_slverr",    rsp.slverr, 0);
        check("wr10_timeout",   rsp.timeout, 0);
        check("wr10_mem",       mem[4], 32'hDEAD_BEEF);

        // ---- read with 3 wait states, response back-pressured 5 cycles ----
        run_xfer("rd10", 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b0, 5, en, rsp);
        check("rd10_en_cycles", en, 4);
        check("rd10_rdata",     rsp.rdata, 32'hDEAD_BEEF);
        check("rd10_slverr",    rsp.slverr, 0);
        check("rd10_timeout",   rsp.timeout, 0);

        // ---- read with slave error ----
        run_xfer("rd20err", 1'b0, 32'h20, 32'h0, 0, 1'b1, 1'b0, 0, en, rsp);
        check("rd20err_en_cycles", en, 1);
        check("rd20err_rdata",     rsp.rdata, 32'h1234_5678);
        check("rd20err_slverr",    rsp.slverr, 1);
        check("rd20err_timeout",   rsp.timeout, 0);

        // ---- slave never ready: timeout after TIMEOUT=4 ACCESS cycles ----
        run_xfer("rd30to", 1'b0, 32'h30, 32'h0, 0, 1'b0, 1'b1, 1, en, rsp);
        check("rd30to_en_cycles", en, 4);
        check("rd30to_rdata",     rsp.rdata, 0);
        check("rd30to_slverr",    rsp.slverr, 1);
        check("rd30to_timeout",   rsp.timeout, 1);
        slv_hang = 1'b0;

        // ---- reset during ACCESS after 2 waits ----
        slv_waits    = 10;
        rq.req_valid = 1'b1;
        rq.req_write = 1'b0;
        rq.req_addr  = 32'h18;
        @(posedge pclk); #1;
        rq.req_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("mid_in_access", apb.PENABLE, 1);
        preset = 1'b1;
        @(posedge pclk); #1;
        check("mid_rst_psel",      apb.PSEL, 0);
        check("mid_rst_penable",   apb.PENABLE, 0);
        check("mid_rst_rsp_valid", rq.rsp_valid, 0);
        check("mid_rst_req_ready", rq.req_ready, 0);
        preset = 1'b0;
        #1;

        // ---- normal traffic after reset ----
        run_xfer("wr14", 1'b1, 32'h14, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 0, en, rsp);
        check("wr14_en_cycles", en, 1);
        check("wr14_slverr",    rsp.slverr, 0);
        check("wr14_mem",       mem[5], 32'hCAFE_F00D);

        run_xfer("rd14", 1'b0, 32'h14, 32'h0, 1, 1'b0, 1'b0, 0, en, rsp);
        check("rd14_en_cycles", en, 2);
        check("rd14_rdata",     rsp.rdata, 32'hCAFE_F00D);
        check("rd14_timeout",   rsp.timeout, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
